// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART frame packer: header bytes, frame
// geometry, FSM state encoding and the checksum helper.
package uart_frame_pkg;

    localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
    localparam logic [7:0] HDR1_DEFAULT = 8'h55;

    // Frame is HDR0, HDR1, three data bytes (MSB first), checksum.
    localparam int         FRAME_LEN = 6;
    localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

    // Cycles spent after each write before trusting tx_busy again.
    localparam int GUARD_CYCLES = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    // Modulo-256 sum of the three data bytes; carries fall off the top.
    function automatic logic [7:0] frame_chk(input logic [7:0] b2,
                                             input logic [7:0] b1,
                                             input logic [7:0] b0);
        return b2 + b1 + b0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with occupancy count. The head entry is read
// combinationally so the consumer can capture it on the same edge it pops.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
    assign level = level_reg;
    assign dout  = mem[rd_ptr_reg];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_packer.sv
// Queues accumulated ADC sums and serialises each one as a 6-byte frame
// (two header bytes, three data bytes, checksum) into a UART transmitter.
module uart_frame_packer
    import uart_frame_pkg::*;
#(
    parameter int         SUM_W = 24,
    parameter int         DEPTH = 4,
    parameter logic [7:0] HDR0  = HDR0_DEFAULT,
    parameter logic [7:0] HDR1  = HDR1_DEFAULT
) (
    input  logic                   clk_40M,
    input  logic                   rst_n,
    input  logic [SUM_W-1:0]       sum_in,
    input  logic                   sum_valid,
    input  logic                   tx_busy,
    output logic [7:0]             tx_data,
    output logic                   tx_wren,
    output logic                   frame_active,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             drop_cnt
);

    logic [2:0]       state_reg;
    logic [2:0]       byte_idx_reg;
    logic [0:0]       guard_cnt_reg;
    logic [SUM_W-1:0] frame_reg;
    logic [7:0]       chk_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_wren_reg;
    logic [7:0]       drop_cnt_reg;
    logic [7:0]       byte_next;

    logic [SUM_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             drop;

    // The FSM takes a sample only while idle, so frames are never interrupted.
    assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;
    assign drop     = sum_valid && fifo_full && !fifo_pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SUM_W)
    ) u_fifo (
        .clk   (clk_40M),
        .rst_n (rst_n),
        .push  (sum_valid),
        .pop   (fifo_pop),
        .din   (sum_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Byte mux: selects the frame byte addressed by byte_idx.
    always_comb begin
        byte_next = chk_reg;
        case (byte_idx_reg)
            3'd0:    byte_next = HDR0;
            3'd1:    byte_next = HDR1;
            3'd2:    byte_next = frame_reg[SUM_W-1  -: 8];
            3'd3:    byte_next = frame_reg[SUM_W-9  -: 8];
            3'd4:    byte_next = frame_reg[SUM_W-17 -: 8];
            default: byte_next = chk_reg;
        endcase
    end

    // Saturating count of samples lost to a full queue.
    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    // Frame sequencer: pop, compute checksum, then write one byte per handshake.
    always_ff @(posedge clk_40M or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            byte_idx_reg  <= '0;
            guard_cnt_reg <= '0;
            frame_reg     <= '0;
            chk_reg       <= '0;
            tx_data_reg   <= '0;
            tx_wren_reg   <= 1'b0;
        end else begin
            tx_wren_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        frame_reg    <= fifo_dout;
                        byte_idx_reg <= '0;
                        state_reg    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    chk_reg   <= frame_chk(frame_reg[SUM_W-1  -: 8],
                                           frame_reg[SUM_W-9  -: 8],
                                           frame_reg[SUM_W-17 -: 8]);
                    state_reg <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data_reg   <= byte_next;
                        tx_wren_reg   <= 1'b1;
                        guard_cnt_reg <= '0;
                        state_reg     <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    // tx_busy may not have risen yet; hold off before sampling it.
                    if (guard_cnt_reg == 1'(GUARD_CYCLES - 1)) begin
                        state_reg <= ST_WAIT;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (byte_idx_reg == LAST_IDX) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 3'd1;
                            state_reg    <= ST_SEND;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tx_data      = tx_data_reg;
    assign tx_wren      = tx_wren_reg;
    assign frame_active = (state_reg != ST_IDLE);
    assign drop_cnt     = drop_cnt_reg;

endmodule
